// File: rtl/msk_and_hpc3_arbiter.sv
// Round-robin arbiter sharing one HPC3 masked-AND gadget (1-cycle latency) between
// NREQ requesters. It also supplies the gadget's delayed inb_prev copy and routes each result back.
module msk_and_hpc3_arbiter #(
    parameter int d    = 2,
    parameter int NREQ = 2,
    parameter int RNDW = d * (d - 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*d-1:0]   req_a,
    input  logic [NREQ*d-1:0]   req_b,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [d-1:0]        rsp_data,
    input  logic                prng_valid,
    output logic                prng_ready,
    input  logic [RNDW-1:0]     prng_data,
    output logic [d-1:0]        g_ina,
    output logic [d-1:0]        g_inb,
    output logic [d-1:0]        g_inb_prev,
    output logic [RNDW-1:0]     g_rnd,
    input  logic [d-1:0]        g_out,
    output logic                busy
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [NREQ-1:0]  tag_q;
    logic [d-1:0]     inb_prev_q;
    logic [PTR_W-1:0] winner;
    logic             issue;
    logic [NREQ-1:0]  grant;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin : pick_winner
        logic             found;
        logic [PTR_W:0]   cand;
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        found  = 1'b0;
        cand   = '0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(NREQ))
                cand = cand - (PTR_W+1)'(NREQ);
            if (!found && req_valid[cand[PTR_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[PTR_W-1:0];
            end
        end
    end

    assign issue      = prng_valid && (|req_valid);
    assign grant      = issue ? (NREQ'(1) << winner) : '0;
    assign req_ready  = grant;
    assign prng_ready = issue;

    // Pure selection: shares are never combined here, idle cycles drive zeros.
    assign g_ina = issue ? req_a[winner*d +: d] : '0;
    assign g_inb = issue ? req_b[winner*d +: d] : '0;
    assign g_rnd = issue ? prng_data : '0;

    // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= '0;
            tag_q      <= '0;
            inb_prev_q <= '0;
        end else begin
            tag_q      <= grant;
            inb_prev_q <= g_inb;
            if (issue) begin
                if (winner == PTR_W'(NREQ - 1))
                    rr_ptr <= '0;
                else
                    rr_ptr <= winner + 1'b1;
            end
        end
    end

    assign g_inb_prev = inb_prev_q;
    assign rsp_valid  = tag_q;
    assign rsp_data   = (|tag_q) ? g_out : '0;
    assign busy       = |tag_q;

endmodule

// File: tb/tb_msk_and_hpc3_arbiter.sv
// Bench for msk_and_hpc3_arbiter: directed checks on a d=2/NREQ=2 instance and a
// randomized scoreboard run on a d=3/NREQ=4 instance, each with a behavioural gadget stub.
module tb_msk_and_hpc3_arbiter;

    localparam int D2 = 2, N2 = 2, RW2 = D2 * (D2 - 1);
    localparam int D3 = 3, N4 = 4, RW3 = D3 * (D3 - 1);
    localparam int RAND_CYCLES = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- small instance (d=2, NREQ=2) ----------------
    logic            s_rst;
    logic [N2-1:0]   s_req_valid, s_req_ready, s_rsp_valid;
    logic [N2*D2-1:0] s_req_a, s_req_b;
    logic [D2-1:0]   s_rsp_data, s_g_ina, s_g_inb, s_g_inb_prev, s_g_out;
    logic            s_prng_valid, s_prng_ready, s_busy;
    logic [RW2-1:0]  s_prng_data, s_g_rnd;

    msk_and_hpc3_arbiter #(.d(D2), .NREQ(N2), .RNDW(RW2)) dut_s (
        .clk(clk), .rst(s_rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready),
        .req_a(s_req_a), .req_b(s_req_b),
        .rsp_valid(s_rsp_valid), .rsp_data(s_rsp_data),
        .prng_valid(s_prng_valid), .prng_ready(s_prng_ready), .prng_data(s_prng_data),
        .g_ina(s_g_ina), .g_inb(s_g_inb), .g_inb_prev(s_g_inb_prev),
        .g_rnd(s_g_rnd), .g_out(s_g_out), .busy(s_busy)
    );

    // Gadget stub: result built from registered A, the arbiter's inb_prev and a rnd-derived mask.
    logic [D2-1:0]  s_ina_q;
    logic [RW2-1:0] s_rnd_q;
    always_ff @(posedge clk) begin
        s_ina_q <= s_g_ina;
        s_rnd_q <= s_g_rnd;
    end
    assign s_g_out = {^s_rnd_q, (^s_ina_q & ^s_g_inb_prev) ^ (^s_rnd_q)};

    // ---------------- random instance (d=3, NREQ=4) ----------------
    logic             r_rst;
    logic [N4-1:0]    r_req_valid, r_req_ready, r_rsp_valid;
    logic [N4*D3-1:0] r_req_a, r_req_b;
    logic [D3-1:0]    r_rsp_data, r_g_ina, r_g_inb, r_g_inb_prev, r_g_out;
    logic             r_prng_valid, r_prng_ready, r_busy;
    logic [RW3-1:0]   r_prng_data, r_g_rnd;

    msk_and_hpc3_arbiter #(.d(D3), .NREQ(N4), .RNDW(RW3)) dut_r (
        .clk(clk), .rst(r_rst),
        .req_valid(r_req_valid), .req_ready(r_req_ready),
        .req_a(r_req_a), .req_b(r_req_b),
        .rsp_valid(r_rsp_valid), .rsp_data(r_rsp_data),
        .prng_valid(r_prng_valid), .prng_ready(r_prng_ready), .prng_data(r_prng_data),
        .g_ina(r_g_ina), .g_inb(r_g_inb), .g_inb_prev(r_g_inb_prev),
        .g_rnd(r_g_rnd), .g_out(r_g_out), .busy(r_busy)
    );

    logic [D3-1:0]  r_ina_q;
    logic [RW3-1:0] r_rnd_q;
    always_ff @(posedge clk) begin
        r_ina_q <= r_g_ina;
        r_rnd_q <= r_g_rnd;
    end
    assign r_g_out = {1'b0, ^r_rnd_q, (^r_ina_q & ^r_g_inb_prev) ^ (^r_rnd_q)};

    // ---------------- scoreboard + monitor for the random instance ----------------
    typedef struct {
        logic [N4-1:0] tag;
        logic          res;
        logic [D3-1:0] b;
    } exp_t;

    exp_t sb[$];
    logic mon_en = 1'b0;

    // Samples 1 time unit after the edge, before the stimulus pushes this cycle's issue.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_valid", r_rsp_valid, e.tag);
                check("rsp_unmasked", ^r_rsp_data, e.res);
                check("inb_prev", r_g_inb_prev, e.b);
                check("busy", r_busy, 1);
            end else begin
                check("rsp_valid_idle", r_rsp_valid, 0);
                check("rsp_data_idle", r_rsp_data, 0);
                check("inb_prev_idle", r_g_inb_prev, 0);
                check("busy_idle", r_busy, 0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    // Reference model state for the random run.
    int ptr;
    int waits[N4];
    int model_issues, words_seen;

    initial begin
        s_rst = 1'b1; s_req_valid = '0; s_req_a = '0; s_req_b = '0;
        s_prng_valid = 1'b0; s_prng_data = '0;
        r_rst = 1'b1; r_req_valid = '0; r_req_a = '0; r_req_b = '0;
        r_prng_valid = 1'b0; r_prng_data = '0;

        // Reset state.
        cyc(); cyc(); settle();
        check("reset_rsp_valid", s_rsp_valid, 0);
        check("reset_busy", s_busy, 0);
        check("reset_inb_prev", s_g_inb_prev, 0);
        check("reset_rsp_data", s_rsp_data, 0);

        // Requests pending while reset is held: registers stay clear.
        s_req_valid = 2'b11; s_prng_valid = 1'b1; s_prng_data = 2'b10; s_req_b = 4'b1111;
        cyc(); settle();
        check("reset_hold_inb_prev", s_g_inb_prev, 0);
        check("reset_hold_busy", s_busy, 0);

        // Round-robin after reset: 01 first, then alternating.
        s_rst = 1'b0;
        settle();
        check("rr_first", s_req_ready, 2'b01);
        check("rr_prng_ready", s_prng_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(); settle();
            check("rr_alt", s_req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
        end

        // Single op from requester 0: a=01, b=11, rnd=0.
        cyc();
        s_req_valid = 2'b01; s_req_a = 4'b0001; s_req_b = 4'b0011; s_prng_data = 2'b00;
        settle();
        check("op_ready", s_req_ready, 2'b01);
        check("op_ina", s_g_ina, 2'b01);
        check("op_inb", s_g_inb, 2'b11);
        check("op_rnd", s_g_rnd, 2'b00);
        cyc();
        s_req_a = 4'b0001; s_req_b = 4'b0010; s_prng_data = 2'b11;
        settle();
        check("op_inb_prev", s_g_inb_prev, 2'b11);
        check("op_rsp_valid", s_rsp_valid, 2'b01);
        check("op_rsp_unmasked", ^s_rsp_data, 1'b1 & 1'b0);
        check("op_busy", s_busy, 1);
        check("op2_inb", s_g_inb, 2'b10);
        cyc();
        s_req_valid = 2'b00;
        settle();
        check("op2_rsp_valid", s_rsp_valid, 2'b01);
        check("op2_rsp_unmasked", ^s_rsp_data, 1'b1 & 1'b1);
        check("op2_inb_prev", s_g_inb_prev, 2'b10);
        check("idle_ina", s_g_ina, 0);

        // PRNG stall: no issue, no stale shares, even with a request pending.
        for (int i = 0; i < 3; i++) begin
            cyc();
            s_req_valid = 2'b01; s_prng_valid = 1'b0; s_prng_data = 2'b11;
            settle();
            check("stall_ready", s_req_ready, 0);
            check("stall_prng_ready", s_prng_ready, 0);
            check("stall_ina", s_g_ina, 0);
            check("stall_inb", s_g_inb, 0);
            check("stall_rnd", s_g_rnd, 0);
        end
        cyc();
        s_prng_valid = 1'b1;
        settle();
        check("stall_release_ready", s_req_ready, 2'b01);
        check("stall_release_prng", s_prng_ready, 1);

        // Back-to-back ops from requesters 0 then 1.
        cyc();
        s_req_valid = 2'b01; s_req_b = 4'b1001;
        settle();
        check("b2b_t_ready", s_req_ready, 2'b01);
        cyc();
        s_req_valid = 2'b10;
        settle();
        check("b2b_t1_ready", s_req_ready, 2'b10);
        check("b2b_t1_rsp", s_rsp_valid, 2'b01);
        check("b2b_t1_inb_prev", s_g_inb_prev, 2'b01);
        cyc();
        s_req_valid = 2'b00;
        settle();
        check("b2b_t2_rsp", s_rsp_valid, 2'b10);
        check("b2b_t2_inb_prev", s_g_inb_prev, 2'b10);

        // Reset with an op in flight drops the result and clears the pointer.
        cyc();
        s_req_valid = 2'b01;
        settle();
        check("rst_flight_issue", s_req_ready, 2'b01);
        cyc();
        s_rst = 1'b1; s_req_valid = 2'b00;
        settle();
        check("rst_flight_busy", s_busy, 1);
        cyc();
        s_rst = 1'b0; s_req_valid = 2'b11;
        settle();
        check("rst_drop_rsp_valid", s_rsp_valid, 0);
        check("rst_drop_busy", s_busy, 0);
        check("rst_drop_inb_prev", s_g_inb_prev, 0);
        check("rst_drop_rsp_data", s_rsp_data, 0);
        check("rst_ptr_cleared", s_req_ready, 2'b01);
        s_req_valid = 2'b00;

        // ---------------- randomized run ----------------
        ptr = 0; model_issues = 0; words_seen = 0;
        for (int i = 0; i < N4; i++) waits[i] = 0;
        cyc();
        r_rst = 1'b0;
        mon_en = 1'b1;
        for (int c = 0; c < RAND_CYCLES; c++) begin
            logic        iss;
            int          w;
            logic [D3-1:0] a_sl, b_sl;
            cyc();
            r_rst        = ($urandom_range(0, 99) == 0);
            r_req_valid  = ($urandom_range(0, 3) == 0) ? N4'(1 << $urandom_range(0, N4 - 1))
                                                         : N4'($urandom_range(0, 15));
            r_prng_valid = ($urandom_range(0, 3) != 0);
            r_prng_data  = RW3'($urandom);
            r_req_a      = (N4*D3)'($urandom);
            r_req_b      = (N4*D3)'($urandom);
            settle();

            iss = r_prng_valid && (r_req_valid != 0);
            w = 0;
            for (int k = N4 - 1; k >= 0; k--)
                if (r_req_valid[(ptr + k) % N4]) w = (ptr + k) % N4;
            a_sl = r_req_a[w*D3 +: D3];
            b_sl = r_req_b[w*D3 +: D3];

            check("r_req_ready", r_req_ready, iss ? (64'd1 << w) : 64'd0);
            check("r_prng_ready", r_prng_ready, iss);
            check("r_ina", r_g_ina, iss ? a_sl : '0);
            check("r_inb", r_g_inb, iss ? b_sl : '0);
            check("r_rnd", r_g_rnd, iss ? r_prng_data : '0);
            if (r_prng_ready) words_seen++;

            if (iss) begin
                model_issues++;
                for (int i = 0; i < N4; i++) begin
                    if (i == w) begin
                        check("r_no_starve", waits[i] <= N4 - 1, 1);
                        waits[i] = 0;
                    end else if (r_req_valid[i]) waits[i]++;
                    else waits[i] = 0;
                end
            end else begin
                for (int i = 0; i < N4; i++)
                    if (!r_req_valid[i]) waits[i] = 0;
            end

            if (r_rst) begin
                ptr = 0;
                for (int i = 0; i < N4; i++) waits[i] = 0;
            end else if (iss) begin
                exp_t e;
                e.tag = N4'(1 << w);
                e.res = (^a_sl) & (^b_sl);
                e.b   = b_sl;
                sb.push_back(e);
                ptr = (w + 1) % N4;
            end
        end
        cyc();
        r_rst = 1'b0; r_req_valid = '0; r_prng_valid = 1'b0;
        cyc(); cyc();
        mon_en = 1'b0;
        check("r_words_per_issue", words_seen, model_issues);
        check("r_sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
